// File: rtl/dpram_pingpong_buf_pkg.sv
// Shared definitions for the ping-pong buffer: bank-state encoding, error codes
// and a constant-evaluable clog2.
package pkg_dpram_buf;

  typedef enum logic [1:0] {
    BS_EMPTY   = 2'd0,
    BS_FILLING = 2'd1,
    BS_FULL    = 2'd2,
    BS_READING = 2'd3
  } bank_st_e;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_RD_RANGE  = 2'b01;
  localparam logic [1:0] ERR_DONE_IDLE = 2'b10;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dpram_pingpong_buf_if.sv
// Writer stream, reader random-access and bank handshake of the ping-pong buffer.
interface dpram_pingpong_buf_if #(
  parameter int DW = 16,
  parameter int AW = 13
) ();
  localparam int NB = DW / 8;

  logic          wr_vld;
  logic          wr_rdy;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_ben;
  logic          wr_last;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic          rd_avail;
  logic [AW:0]   rd_len;
  logic          rd_done;
  logic          err;

  modport slave (
    input  wr_vld, wr_data, wr_ben, wr_last, rd_en, rd_addr, rd_done,
    output wr_rdy, rd_vld, rd_data, rd_avail, rd_len, err
  );

  modport master (
    output wr_vld, wr_data, wr_ben, wr_last, rd_en, rd_addr, rd_done,
    input  wr_rdy, rd_vld, rd_data, rd_avail, rd_len, err
  );
endinterface

// File: rtl/dpram_pingpong_buf_dpram_bhv.sv
// Behavioural dual-port RAM holding both banks; port A writes with byte enables,
// port B reads into an output register. Swappable for a technology macro wrapper.
module dpram_bhv
  import pkg_dpram_buf::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4608,
  parameter int AW    = 13
) (
  input  logic            clk,
  input  logic            cea_n_i,
  input  logic [AW:0]     addra_i,
  input  logic [DW/8-1:0] wea_n_i,
  input  logic [DW-1:0]   da_i,
  input  logic            ceb_n_i,
  input  logic [AW:0]     addrb_i,
  output logic [DW-1:0]   qb_o
);
  localparam int NB = DW / 8;
  localparam int IW = clog2(2 * DEPTH);

  logic [DW-1:0] mem_q [2*DEPTH];
  int            widx;
  int            ridx;

  // {bank, offset} is folded onto a packed 2*DEPTH array so non-power-of-2 depths waste nothing
  function automatic int word_idx(input logic [AW:0] a);
    return (a[AW] ? DEPTH : 0) + int'(a[AW-1:0]);
  endfunction

  assign widx = word_idx(addra_i);
  assign ridx = word_idx(addrb_i);

  always_ff @(posedge clk) begin
    if (!cea_n_i) begin
      for (int i = 0; i < NB; i++) begin
        if (!wea_n_i[i]) mem_q[IW'(widx)][8*i +: 8] <= da_i[8*i +: 8];
      end
    end
    if (!ceb_n_i) begin
      qb_o <= (ridx < 2 * DEPTH) ? mem_q[IW'(ridx)] : '0;
    end
  end
endmodule

// File: rtl/dpram_pingpong_buf.sv
// Two-bank ping-pong buffer: sequential writer fills one bank while the reader
// randomly accesses the other; banks are handed over strictly in fill order.
module dpram_pingpong_buf
  import pkg_dpram_buf::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4608,
  parameter int AW    = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpram_pingpong_buf_if.slave  bus
);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  bank_st_e      bank_st_q [2];
  bank_st_e      bank_st_d [2];
  logic [AW:0]   len_q [2];
  logic [AW:0]   len_d [2];
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          rd_vld_q, rd_seen_q, err_q;
  logic [1:0]    err_code_d;
  logic          wr_rdy, wr_acc, wr_term, rd_avail, rd_go, rd_oor;
  logic [DW-1:0] ram_q;

  assign wr_rdy   = (bank_st_q[wbank_q] == BS_EMPTY) || (bank_st_q[wbank_q] == BS_FILLING);
  assign wr_acc   = bus.wr_vld & wr_rdy;
  assign wr_term  = wr_acc & (bus.wr_last | (wptr_q == LAST_PTR));
  assign rd_avail = (bank_st_q[rbank_q] == BS_READING);
  assign rd_go    = bus.rd_en & rd_avail;
  assign rd_oor   = rd_go & ({1'b0, bus.rd_addr} >= len_q[rbank_q]);

  always_comb begin
    bank_st_d  = bank_st_q;
    len_d      = len_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    wptr_d     = wptr_q;
    err_code_d = ERR_NONE;

    if (wr_term) begin
      len_d[wbank_q]     = {1'b0, wptr_q} + (AW+1)'(1);
      bank_st_d[wbank_q] = BS_FULL;
      wptr_d             = '0;
      wbank_d            = ~wbank_q;
    end else if (wr_acc) begin
      bank_st_d[wbank_q] = BS_FILLING;
      wptr_d             = wptr_q + AW'(1);
    end

    // rbank only advances on release, so the next FULL bank it points at is the oldest one
    if (bus.rd_done && rd_avail) begin
      bank_st_d[rbank_q] = BS_EMPTY;
      rbank_d            = ~rbank_q;
    end else if (!rd_avail && (bank_st_q[rbank_q] == BS_FULL)) begin
      bank_st_d[rbank_q] = BS_READING;
    end

    if (rd_oor) err_code_d = err_code_d | ERR_RD_RANGE;
    if (bus.rd_done && !rd_avail) err_code_d = err_code_d | ERR_DONE_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0] <= BS_EMPTY;
      bank_st_q[1] <= BS_EMPTY;
      len_q[0]     <= '0;
      len_q[1]     <= '0;
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      wptr_q       <= '0;
      rd_vld_q     <= 1'b0;
      rd_seen_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      bank_st_q <= bank_st_d;
      len_q     <= len_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      wptr_q    <= wptr_d;
      rd_vld_q  <= rd_go;
      rd_seen_q <= rd_seen_q | rd_go;
      err_q     <= (err_code_d != ERR_NONE);
    end
  end

  dpram_bhv #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .cea_n_i (~wr_acc),
    .addra_i ({wbank_q, wptr_q}),
    .wea_n_i (bus.wr_ben),
    .da_i    (bus.wr_data),
    .ceb_n_i (~rd_go),
    .addrb_i ({rbank_q, bus.rd_addr}),
    .qb_o    (ram_q)
  );

  // RAM output register is not reset; mask it until the first read after reset
  assign bus.rd_data  = rd_seen_q ? ram_q : '0;
  assign bus.wr_rdy   = wr_rdy;
  assign bus.rd_vld   = rd_vld_q;
  assign bus.rd_avail = rd_avail;
  assign bus.rd_len   = rd_avail ? len_q[rbank_q] : '0;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_dpram_pingpong_buf.sv
// Directed plus randomized bench for dpram_pingpong_buf against a block-queue model.
module tb_dpram_pingpong_buf;
  localparam int DW = 16, DEPTH = 8, AW = 3, NB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dpram_pingpong_buf_if #(.DW(DW), .AW(AW)) bus ();
  dpram_pingpong_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Model: bank contents, queue of filled banks in fill order, bank held by reader
  logic [DW-1:0] m_mem [2][DEPTH];
  int            m_wb, m_wptr, m_rb;
  int            m_len [2];
  int            m_full_q [$];
  bit            m_vld, m_err, m_data_known;
  logic [DW-1:0] m_data;

  function automatic bit m_wr_rdy();
    foreach (m_full_q[k]) if (m_full_q[k] == m_wb) return 1'b0;
    return (m_rb != m_wb);
  endfunction

  function automatic void m_reset();
    m_wb = 0; m_wptr = 0; m_rb = -1;
    m_len[0] = 0; m_len[1] = 0;
    m_full_q.delete();
    m_vld = 0; m_err = 0; m_data = '0; m_data_known = 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("wr_rdy",   32'(bus.wr_rdy),   32'(m_wr_rdy()));
    chk("rd_avail", 32'(bus.rd_avail), 32'(m_rb >= 0));
    chk("rd_len",   32'(bus.rd_len),   (m_rb >= 0) ? 32'(m_len[m_rb]) : 32'd0);
    chk("rd_vld",   32'(bus.rd_vld),   32'(m_vld));
    chk("err",      32'(bus.err),      32'(m_err));
    if (m_data_known) chk("rd_data", 32'(bus.rd_data), 32'(m_data));
  endtask

  task automatic cycle();
    bit acc, take, go;
    int rb0;
    acc  = bus.wr_vld && m_wr_rdy();
    rb0  = m_rb;
    take = (rb0 < 0) && (m_full_q.size() > 0);
    go   = bus.rd_en && (rb0 >= 0);
    m_vld = go;
    m_err = 0;
    if (go) begin
      if (int'(bus.rd_addr) >= m_len[rb0]) begin
        m_err = 1; m_data_known = 0;
      end else begin
        m_data = m_mem[rb0][bus.rd_addr];
        m_data_known = !$isunknown(m_data);
      end
    end
    if (bus.rd_done && rb0 < 0) m_err = 1;
    if (acc) begin
      for (int i = 0; i < NB; i++)
        if (!bus.wr_ben[i]) m_mem[m_wb][m_wptr][8*i +: 8] = bus.wr_data[8*i +: 8];
      if (bus.wr_last || m_wptr == DEPTH - 1) begin
        m_len[m_wb] = m_wptr + 1;
        m_full_q.push_back(m_wb);
        m_wb ^= 1;
        m_wptr = 0;
      end else m_wptr++;
    end
    if (take) m_rb = m_full_q.pop_front();
    else if (bus.rd_done && rb0 >= 0) m_rb = -1;
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  task automatic wr_word(input logic [DW-1:0] d, input logic [NB-1:0] ben, input bit last);
    bus.wr_vld = 1'b1; bus.wr_data = d; bus.wr_ben = ben; bus.wr_last = last;
    cycle();
    bus.wr_vld = 1'b0; bus.wr_last = 1'b0;
  endtask

  task automatic rd_word(input logic [AW-1:0] a);
    bus.rd_en = 1'b1; bus.rd_addr = a;
    cycle();
    bus.rd_en = 1'b0;
  endtask

  task automatic done_pulse();
    bus.rd_done = 1'b1;
    cycle();
    bus.rd_done = 1'b0;
  endtask

  task automatic wait_avail();
    for (int k = 0; k < 8 && !bus.rd_avail; k++) cycle();
    chk("avail_wait", 32'(bus.rd_avail), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_rdy"},   32'(bus.wr_rdy),   32'd1);
    chk({tag, "_rd_vld"},   32'(bus.rd_vld),   32'd0);
    chk({tag, "_rd_data"},  32'(bus.rd_data),  32'd0);
    chk({tag, "_rd_avail"}, 32'(bus.rd_avail), 32'd0);
    chk({tag, "_rd_len"},   32'(bus.rd_len),   32'd0);
    chk({tag, "_err"},      32'(bus.err),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    foreach (m_mem[b, a]) m_mem[b][a] = 'x;
    m_reset();
    bus.wr_vld = 0; bus.wr_data = '0; bus.wr_ben = '0; bus.wr_last = 0;
    bus.rd_en = 0; bus.rd_addr = '0; bus.rd_done = 0;
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Four-word block, then read it back
    for (int i = 0; i < 4; i++) wr_word(16'(16'h1111 * (i + 1)), 2'b00, i == 3);
    chk("t1_avail_early", 32'(bus.rd_avail), 32'd0);
    cycle();
    chk("t1_avail", 32'(bus.rd_avail), 32'd1);
    chk("t1_len", 32'(bus.rd_len), 32'd4);
    for (int i = 0; i < 4; i++) begin
      rd_word(AW'(i));
      chk("t1_vld", 32'(bus.rd_vld), 32'd1);
      chk("t1_data", 32'(bus.rd_data), 32'(16'(16'h1111 * (i + 1))));
    end
    cycle();
    done_pulse();

    // Byte lanes: same bank rewritten two blocks later with only the low lane enabled
    wr_word(16'hAAAA, 2'b00, 1'b1);
    wait_avail();
    done_pulse();
    wr_word(16'(($urandom)), 2'b00, 1'b1);
    wait_avail();
    done_pulse();
    wr_word(16'h5555, 2'b10, 1'b1);
    wait_avail();
    rd_word('0);
    chk("t2_bytelane", 32'(bus.rd_data), 32'h0000AA55);
    done_pulse();

    // Bank0 auto-terminates at DEPTH, bank1 closes at 3 words, writer stalls
    for (int i = 0; i < DEPTH; i++) wr_word(16'($urandom), 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) wr_word(16'($urandom), 2'b00, i == 2);
    chk("t3_wr_rdy_stall", 32'(bus.wr_rdy), 32'd0);
    wr_word(16'hDEAD, 2'b00, 1'b0);
    chk("t3_drop_no_err", 32'(bus.err), 32'd0);
    rd_word(AW'(DEPTH - 1));
    done_pulse();
    chk("t3_wr_rdy_back", 32'(bus.wr_rdy), 32'd1);
    cycle();
    chk("t3_len", 32'(bus.rd_len), 32'd3);
    rd_word(AW'(2));
    rd_word(AW'(0));

    // Out-of-range read and idle rd_done
    rd_word(AW'(5));
    chk("t5_oor_vld", 32'(bus.rd_vld), 32'd1);
    chk("t5_oor_err", 32'(bus.err), 32'd1);
    done_pulse();
    done_pulse();
    chk("t5_idle_done_err", 32'(bus.err), 32'd1);
    chk("t5_idle_done_avail", 32'(bus.rd_avail), 32'd0);

    // Block close and rd_done on the other bank in the same cycle
    wr_word(16'($urandom), 2'b00, 1'b0);
    wr_word(16'($urandom), 2'b00, 1'b1);
    wait_avail();
    wr_word(16'($urandom), 2'b00, 1'b0);
    bus.rd_done = 1'b1;
    wr_word(16'($urandom), 2'b00, 1'b1);
    bus.rd_done = 1'b0;
    chk("t4_no_bubble", 32'(bus.wr_rdy), 32'd1);
    chk("t4_avail_gap", 32'(bus.rd_avail), 32'd0);
    wr_word(16'($urandom), 2'b00, 1'b0);
    chk("t4_avail", 32'(bus.rd_avail), 32'd1);
    chk("t4_len", 32'(bus.rd_len), 32'd2);
    done_pulse();

    // Asynchronous reset mid-block
    wr_word(16'($urandom), 2'b00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    d = 16'($urandom);
    wr_word(d, 2'b00, 1'b1);
    wait_avail();
    chk("t6_len", 32'(bus.rd_len), 32'd1);
    rd_word('0);
    chk("t6_data", 32'(bus.rd_data), 32'(d));
    done_pulse();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.wr_vld  = ($urandom_range(0, 3) != 0);
      bus.wr_data = 16'($urandom);
      bus.wr_ben  = 2'($urandom_range(0, 3));
      bus.wr_last = ($urandom_range(0, 5) == 0);
      bus.rd_en   = ($urandom_range(0, 1) == 1);
      bus.rd_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.rd_done = ($urandom_range(0, 9) == 0);
      cycle();
    end
    bus.wr_vld = 0; bus.wr_last = 0; bus.rd_en = 0; bus.rd_done = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
